// File: rtl/uart_pkg.sv
// uart_pkg: shared UART register bit positions and default FIFO depth
package uart_pkg;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int FCR_FIFO_EN = 0;
  localparam int FCR_TX_FIFO_RST = 2;
  localparam int IER_ETXE = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: register-file/shifter side bundle of the transmit controller
interface uart_tx_ctrl_if #(parameter int DEPTH = 16, parameter int DW = 8);
  logic wr_thr;
  logic [DW-1:0] wdata;
  logic fifo_en;
  logic tx_fifo_rst;
  logic etxe;
  logic iir_thre_rd;
  logic tx_pop;
  logic tx_sreg_empty;
  logic thre;
  logic [DW-1:0] tx_din;
  logic thre_status;
  logic temt;
  logic thre_int;
  logic [$clog2(DEPTH):0] level;
  logic wr_drop;
  modport master (
    output wr_thr, wdata, fifo_en, tx_fifo_rst, etxe, iir_thre_rd, tx_pop, tx_sreg_empty,
    input thre, tx_din, thre_status, temt, thre_int, level, wr_drop
  );
  modport slave (
    input wr_thr, wdata, fifo_en, tx_fifo_rst, etxe, iir_thre_rd, tx_pop, tx_sreg_empty,
    output thre, tx_din, thre_status, temt, thre_int, level, wr_drop
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: transmit holding storage with flush, head overwrite and entry count
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic ovw,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [$clog2(DEPTH):0] level
);
  if (DEPTH == 1) begin : g_reg
    logic [DW-1:0] q;
    logic v;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q <= '0;
        v <= 1'b0;
      end else if (flush) v <= 1'b0;
      else begin
        if (push | ovw) q <= din;
        v <= push | (v & ~pop);
      end
    assign level = v;
    assign dout = v ? q : '0;
  end else begin : g_ram
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk)
      if (!flush) begin
        if (push) mem[wr_ptr] <= din;
        if (ovw) mem[rd_ptr] <= din;
      end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    assign dout = (level != '0) ? mem[rd_ptr] : '0;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit holding FIFO, shifter handshake, THRE/TEMT status and THRE interrupt
// FIFO mode is built only with UART_TX_CTRL_FIFO_EN defined; otherwise a single holding register.
module uart_tx_ctrl import uart_pkg::*; #(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst_n,
  uart_tx_ctrl_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic fifo_mode, flush;
`ifdef UART_TX_CTRL_FIFO_EN
  localparam int FD = DEPTH;
  logic fifo_en_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fifo_en_q <= 1'b0;
    else fifo_en_q <= bus.fifo_en;
  assign fifo_mode = bus.fifo_en;
  assign flush = bus.tx_fifo_rst | (bus.fifo_en ^ fifo_en_q);
`else
  localparam int FD = 1;
  assign fifo_mode = 1'b0;
  assign flush = bus.tx_fifo_rst;
`endif
  localparam int FLW = $clog2(FD) + 1;
  logic [FLW-1:0] lvl;
  logic pop_q, etxe_q, thre_ip, wr_drop_q;
  logic full, pop_adv, blocked, push, pop, ovw, ip_set;
  assign full = fifo_mode ? (lvl == FLW'(FD)) : (lvl != '0);
  // only the rising edge of the shifter's held pop level consumes an entry
  assign pop_adv = bus.tx_pop & ~pop_q & (lvl != '0);
  assign blocked = bus.wr_thr & full & ~pop_adv & ~flush;
  assign push = bus.wr_thr & ~flush & (~full | pop_adv);
  assign pop = pop_adv & ~flush;
  assign ovw = blocked & ~fifo_mode;
  assign ip_set = ((lvl != '0) & (flush | (pop & (lvl == FLW'(1)) & ~push)))
                | (bus.etxe & ~etxe_q & (lvl == '0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pop_q <= 1'b0;
      etxe_q <= 1'b0;
      thre_ip <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      pop_q <= bus.tx_pop;
      etxe_q <= bus.etxe;
      thre_ip <= ip_set | (thre_ip & ~(push | ovw | bus.iir_thre_rd));
      wr_drop_q <= blocked & fifo_mode;
    end
  uart_sync_fifo #(.DEPTH(FD), .DW(DW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .pop(pop),
    .ovw(ovw),
    .din(bus.wdata),
    .dout(bus.tx_din),
    .level(lvl)
  );
  assign bus.thre = (lvl == '0);
  assign bus.thre_status = bus.thre;
  assign bus.temt = bus.thre & bus.tx_sreg_empty;
  assign bus.thre_int = bus.etxe & thre_ip;
  assign bus.level = LW'(lvl);
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed scoreboard bench for uart_tx_ctrl in either build configuration
module tb_uart_tx_ctrl;
  import uart_pkg::*;
  localparam int DEPTH = UART_FIFO_DEPTH;
  localparam int DW = 8;
`ifdef UART_TX_CTRL_FIFO_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_ctrl_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
  uart_tx_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] sb[$];
  logic prev_pop = 1'b0, prev_etxe = 1'b0, prev_fen = 1'b0, exp_ip = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input logic exp_drop);
    int s;
    s = sb.size();
    chk("level", 32'(bus.level), 32'(s));
    chk("tx_din", 32'(bus.tx_din), (s != 0) ? 32'(sb[0]) : 32'd0);
    chk("thre", 32'(bus.thre), 32'(s == 0));
    chk("thre_status", 32'(bus.thre_status), 32'(s == 0));
    chk("temt", 32'(bus.temt), 32'((s == 0) && bus.tx_sreg_empty));
    chk("thre_int", 32'(bus.thre_int), 32'(bus.etxe & exp_ip));
    chk("wr_drop", 32'(bus.wr_drop), 32'(exp_drop));
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic p, input logic fr, input logic iir);
    int eff, old;
    logic pe, fl, acc, drop, set;
    bus.wr_thr = w;
    bus.wdata = d;
    bus.tx_pop = p;
    bus.tx_fifo_rst = fr;
    bus.iir_thre_rd = iir;
    old = sb.size();
    fl = fr | (F && (bus.fifo_en != prev_fen));
    eff = (F && bus.fifo_en) ? DEPTH : 1;
    pe = p & ~prev_pop & (old != 0);
    acc = 1'b0;
    drop = 1'b0;
    if (fl) sb.delete();
    else begin
      if (pe) begin
        chk("pop_head", 32'(bus.tx_din), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (w) begin
        if (sb.size() < eff) begin
          sb.push_back(d);
          acc = 1'b1;
        end else if (eff > 1) drop = 1'b1;
        else begin
          sb[0] = d;
          acc = 1'b1;
        end
      end
    end
    set = (old != 0 && sb.size() == 0) || (bus.etxe && !prev_etxe && old == 0);
    exp_ip = set | (exp_ip & ~(acc | iir));
    prev_pop = p;
    prev_etxe = bus.etxe;
    prev_fen = bus.fifo_en;
    @(posedge clk);
    #1;
    check_outs(drop);
  endtask

  initial begin
    bus.wr_thr = 1'b0;
    bus.wdata = '0;
    bus.fifo_en = F;
    bus.tx_fifo_rst = 1'b0;
    bus.etxe = 1'b0;
    bus.iir_thre_rd = 1'b0;
    bus.tx_pop = 1'b0;
    bus.tx_sreg_empty = 1'b1;
    #1;
    check_outs(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.etxe = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.tx_sreg_empty = 1'b0;
    while (sb.size() != 0) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    bus.tx_sreg_empty = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.fifo_en = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.fifo_en = F;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.etxe = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.etxe = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
    bus.wr_thr = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_ip = 1'b0;
    prev_pop = 1'b0;
    prev_etxe = 1'b0;
    prev_fen = 1'b0;
    check_outs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
